// File: rtl/handshake_rr_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_rr_arbiter
//
// N-to-1 round-robin merge of valid/ready/data streams into a single
// registered output stream. One-cycle latency, one word per cycle sustained
// when the consumer keeps m_ready high. The output register may be drained
// and refilled in the same cycle, so there is no bubble.
//
// Optional build macro: HANDSHAKE_RR_ARB_ID_EN
//   defined   -> adds output m_id carrying the index of the granted input,
//                loaded and held together with m_data.
//   undefined -> no m_id port and no id register.
//
// Ports
//   aclk     in   clock, all logic on rising edge
//   aresetn  in   asynchronous active-low reset
//   s_valid  in   [N_PORTS]             per-input valid
//   s_ready  out  [N_PORTS]             per-input ready, at most one bit high
//   s_data   in   [N_PORTS*DATA_WIDTH]  input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_valid  out  registered output valid
//   m_ready  in   output ready from downstream
//   m_data   out  [DATA_WIDTH]          registered output data
//   m_id     out  [ID_WIDTH]            granted index (macro builds only)
// -----------------------------------------------------------------------------
module handshake_rr_arbiter #(
   parameter  int N_PORTS    = 4,
   parameter  int DATA_WIDTH = 64,
   localparam int ID_WIDTH   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [N_PORTS-1:0]            s_valid,
   output logic [N_PORTS-1:0]            s_ready,
   input  logic [N_PORTS*DATA_WIDTH-1:0] s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
`ifdef HANDSHAKE_RR_ARB_ID_EN
   output logic [ID_WIDTH-1:0]           m_id,
`endif
   output logic [DATA_WIDTH-1:0]         m_data
);

   logic [ID_WIDTH-1:0]   ptr;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  grant_valid;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  load;
   logic                  xfer;
   // Low during reset and for the first cycle after release, so no input
   // sees ready until the first clock edge after aresetn goes high.
   logic                  rst_done;

   // Round-robin search starting at ptr, wrapping explicitly at N_PORTS so
   // non-power-of-two port counts never land on a non-existent input.
   always_comb begin
      int idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_data  = '0;
      idx         = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_PORTS) begin
            idx = idx - N_PORTS;
         end
         if (!grant_valid && s_valid[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx[ID_WIDTH-1:0];
            grant_data  = s_data[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Output register accepts a new word when empty or being drained now.
   assign load = !m_valid || m_ready;
   assign xfer = load && grant_valid && rst_done;

   always_comb begin
      s_ready = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         s_ready[i] = xfer && (grant_idx == ID_WIDTH'(i));
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rst_done <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         ptr      <= '0;
      end else begin
         rst_done <= 1'b1;
         if (load && rst_done) begin
            if (grant_valid) begin
               m_valid <= 1'b1;
               m_data  <= grant_data;
               if (grant_idx == ID_WIDTH'(N_PORTS - 1)) begin
                  ptr <= '0;
               end else begin
                  ptr <= grant_idx + ID_WIDTH'(1);
               end
            end else begin
               m_valid <= 1'b0;
            end
         end
      end
   end

`ifdef HANDSHAKE_RR_ARB_ID_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_id <= '0;
      end else if (xfer) begin
         m_id <= grant_idx;
      end
   end
`endif

endmodule
